// File: rtl/stage_fetch_wide.sv
`default_nettype none
// ============================================================================
//  Module   : stage_fetch_wide
//  Purpose  : Wide fetch stage. Trims each icache bundle to its leading run of
//             hit lanes, consults the branch predictor on the first
//             control-flow lane and emits the bundle to the instruction buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module stage_fetch_wide #(
    parameter int          FETCH_WIDTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              icache_addr,
    input  logic [32*FETCH_WIDTH-1:0] icache_data,
    input  logic [FETCH_WIDTH-1:0]   icache_valid,
    input  logic [CNT_W-1:0]         ib_free,
    output logic [FETCH_WIDTH-1:0]   fetch_valid,
    output logic [32*FETCH_WIDTH-1:0] fetch_inst,
    output logic [32*FETCH_WIDTH-1:0] fetch_pc,
    output logic [FETCH_WIDTH-1:0]   fetch_pred_taken,
    output logic [31:0]              fetch_pred_target,
    output logic                     bp_req_valid,
    output logic [31:0]              bp_req_pc,
    input  logic                     bp_resp_valid,
    input  logic                     bp_resp_taken,
    input  logic [31:0]              bp_resp_target,
    input  logic                     mispredict,
    input  logic [31:0]              pc_update_addr
);

    localparam int          LANE_W      = $clog2(FETCH_WIDTH);
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [31:0] c_ALIGN     = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        S_FETCH   = 1'b0,
        S_PREDICT = 1'b1
    } state_t;

    state_t                    r_state, w_nxt_state;
    logic [31:0]               r_pc, w_nxt_pc;
    logic [FETCH_WIDTH-1:0]    r_fetch_valid, w_nxt_valid;
    logic [32*FETCH_WIDTH-1:0] r_fetch_inst, w_nxt_inst;
    logic [32*FETCH_WIDTH-1:0] r_fetch_pc, w_nxt_pcs;
    logic [FETCH_WIDTH-1:0]    r_pred_taken, w_nxt_taken;
    logic [31:0]               r_pred_target, w_nxt_target;
    logic                      r_bp_req_valid, w_nxt_req;
    logic [31:0]               r_bp_req_pc, w_nxt_req_pc;
    logic [32*FETCH_WIDTH-1:0] r_lat_inst, w_nxt_lat_inst;
    logic [LANE_W-1:0]         r_lat_b, w_nxt_lat_b;

    logic [CNT_W-1:0]          w_n;
    logic                      w_has_br;
    logic [LANE_W-1:0]         w_b;
    logic [CNT_W-1:0]          w_need;
    logic                      w_stall;

    // Bundle decode: leading-hit count, first control-flow lane, stall test
    always_comb begin : p_decode
        logic       run;
        logic [6:0] op;
        w_n      = '0;
        w_has_br = 1'b0;
        w_b      = '0;
        run      = 1'b1;
        op       = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (run && icache_valid[k]) begin
                w_n = w_n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        // Descending scan so the lowest qualifying lane is the one kept
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            op = icache_data[32*k +: 7];
            if ((CNT_W'(k) < w_n) &&
                (op == c_OP_BRANCH || op == c_OP_JAL || op == c_OP_JALR)) begin
                w_has_br = 1'b1;
                w_b      = LANE_W'(k);
            end
        end
        w_need  = w_has_br ? (CNT_W'(w_b) + CNT_W'(1)) : w_n;
        w_stall = (w_n == '0) || (ib_free < w_need);
    end

    // Next-state, next-PC and next output-register values
    always_comb begin : p_next
        w_nxt_state    = r_state;
        w_nxt_pc       = r_pc;
        w_nxt_valid    = '0;
        w_nxt_inst     = '0;
        w_nxt_pcs      = '0;
        w_nxt_taken    = '0;
        w_nxt_target   = '0;
        w_nxt_req      = 1'b0;
        w_nxt_req_pc   = '0;
        w_nxt_lat_inst = r_lat_inst;
        w_nxt_lat_b    = r_lat_b;
        if (mispredict) begin
            // Redirect wins over everything, including a same-cycle response
            w_nxt_state = S_FETCH;
            w_nxt_pc    = pc_update_addr & c_ALIGN;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!w_stall) begin
                        if (w_has_br) begin
                            w_nxt_lat_inst = icache_data;
                            w_nxt_lat_b    = w_b;
                            w_nxt_req      = 1'b1;
                            w_nxt_req_pc   = r_pc + (32'(w_b) << 2);
                            w_nxt_state    = S_PREDICT;
                        end else begin
                            for (int k = 0; k < FETCH_WIDTH; k++) begin
                                if (CNT_W'(k) < w_n) begin
                                    w_nxt_valid[k]       = 1'b1;
                                    w_nxt_inst[32*k +: 32] = icache_data[32*k +: 32];
                                    w_nxt_pcs[32*k +: 32]  = r_pc + 32'(k * 4);
                                end
                            end
                            w_nxt_pc = r_pc + (32'(w_n) << 2);
                        end
                    end
                end
                S_PREDICT: begin
                    if (bp_resp_valid) begin
                        for (int k = 0; k < FETCH_WIDTH; k++) begin
                            if (CNT_W'(k) <= CNT_W'(r_lat_b)) begin
                                w_nxt_valid[k]         = 1'b1;
                                w_nxt_inst[32*k +: 32] = r_lat_inst[32*k +: 32];
                                w_nxt_pcs[32*k +: 32]  = r_pc + 32'(k * 4);
                            end
                        end
                        if (bp_resp_taken) begin
                            w_nxt_taken[r_lat_b] = 1'b1;
                            w_nxt_target         = bp_resp_target;
                            w_nxt_pc             = bp_resp_target & c_ALIGN;
                        end else begin
                            w_nxt_pc = r_pc + ((32'(r_lat_b) + 32'd1) << 2);
                        end
                        w_nxt_state = S_FETCH;
                    end
                end
                default: w_nxt_state = S_FETCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // PC, latched bundle and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_fetch_valid  <= '0;
            r_fetch_inst   <= '0;
            r_fetch_pc     <= '0;
            r_pred_taken   <= '0;
            r_pred_target  <= '0;
            r_bp_req_valid <= 1'b0;
            r_bp_req_pc    <= '0;
            r_lat_inst     <= '0;
            r_lat_b        <= '0;
        end else begin
            r_pc           <= w_nxt_pc;
            r_fetch_valid  <= w_nxt_valid;
            r_fetch_inst   <= w_nxt_inst;
            r_fetch_pc     <= w_nxt_pcs;
            r_pred_taken   <= w_nxt_taken;
            r_pred_target  <= w_nxt_target;
            r_bp_req_valid <= w_nxt_req;
            r_bp_req_pc    <= w_nxt_req_pc;
            r_lat_inst     <= w_nxt_lat_inst;
            r_lat_b        <= w_nxt_lat_b;
        end
    end

    // PC is held unchanged throughout PREDICT, so both states present it
    assign icache_addr       = r_pc;
    assign fetch_valid       = r_fetch_valid;
    assign fetch_inst        = r_fetch_inst;
    assign fetch_pc          = r_fetch_pc;
    assign fetch_pred_taken  = r_pred_taken;
    assign fetch_pred_target = r_pred_target;
    assign bp_req_valid      = r_bp_req_valid;
    assign bp_req_pc         = r_bp_req_pc;

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch_wide.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_fetch_wide
//  Purpose  : Directed scoreboard bench for stage_fetch_wide (4 lanes,
//             reset PC 0x100).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stage_fetch_wide;

    localparam int FW = 4;
    localparam int CW = 3;

    localparam logic [31:0] c_BEQ = 32'h0020_8463;
    localparam logic [31:0] c_JAL = 32'h0080_006F;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     icache_addr;
    logic [32*FW-1:0] icache_data = '0;
    logic [FW-1:0]   icache_valid = '0;
    logic [CW-1:0]   ib_free = 3'd4;
    logic [FW-1:0]   fetch_valid;
    logic [32*FW-1:0] fetch_inst;
    logic [32*FW-1:0] fetch_pc;
    logic [FW-1:0]   fetch_pred_taken;
    logic [31:0]     fetch_pred_target;
    logic            bp_req_valid;
    logic [31:0]     bp_req_pc;
    logic            bp_resp_valid = 1'b0;
    logic            bp_resp_taken = 1'b0;
    logic [31:0]     bp_resp_target = '0;
    logic            mispredict = 1'b0;
    logic [31:0]     pc_update_addr = '0;

    typedef struct {
        logic [FW-1:0]    v;
        logic [32*FW-1:0] inst;
        logic [32*FW-1:0] pc;
        logic [FW-1:0]    tk;
        logic [31:0]      tg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    stage_fetch_wide #(
        .FETCH_WIDTH (FW),
        .RESET_PC    (32'h0000_0100),
        .CNT_W       (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .icache_addr       (icache_addr),
        .icache_data       (icache_data),
        .icache_valid      (icache_valid),
        .ib_free           (ib_free),
        .fetch_valid       (fetch_valid),
        .fetch_inst        (fetch_inst),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .bp_req_valid      (bp_req_valid),
        .bp_req_pc         (bp_req_pc),
        .bp_resp_valid     (bp_resp_valid),
        .bp_resp_taken     (bp_resp_taken),
        .bp_resp_target    (bp_resp_target),
        .mispredict        (mispredict),
        .pc_update_addr    (pc_update_addr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu(input int id);
        return 32'h0000_0013 | (32'(id) << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Queue the bundle expected for lanes 0..n-1 of data starting at base
    task automatic push_exp(input int n, input logic [31:0] base, input logic [32*FW-1:0] data,
                            input logic [FW-1:0] tk, input logic [31:0] tg);
        exp_t e;
        e.v = '0; e.inst = '0; e.pc = '0;
        for (int k = 0; k < n; k++) begin
            e.v[k]           = 1'b1;
            e.inst[32*k +: 32] = data[32*k +: 32];
            e.pc[32*k +: 32]   = base + 32'(4 * k);
        end
        e.tk = tk;
        e.tg = tg;
        exp_q.push_back(e);
    endtask

    task automatic redirect(input logic [31:0] addr);
        @(negedge clock);
        icache_valid   = '0;
        mispredict     = 1'b1;
        pc_update_addr = addr;
        @(negedge clock);
        mispredict     = 1'b0;
    endtask

    // Monitor: compares every emitted bundle against the scoreboard head
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset && fetch_valid != '0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bundle: unexpected output valid=%b pc0=0x%08h, none expected",
                             fetch_valid, fetch_pc[31:0]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (fetch_valid !== e.v || fetch_inst !== e.inst || fetch_pc !== e.pc ||
                        fetch_pred_taken !== e.tk || fetch_pred_target !== e.tg) begin
                        n_err++;
                        $display("FAIL bundle: got v=%b inst=%h pc=%h tk=%b tg=%h expected v=%b inst=%h pc=%h tk=%b tg=%h",
                                 fetch_valid, fetch_inst, fetch_pc, fetch_pred_taken, fetch_pred_target,
                                 e.v, e.inst, e.pc, e.tk, e.tg);
                    end
                end
            end
        end
    end

    logic [32*FW-1:0] d_alu;
    logic [32*FW-1:0] d_br;
    logic [32*FW-1:0] d_jal;

    initial begin
        d_alu = {alu(3), alu(2), alu(1), alu(0)};
        d_br  = {alu(7), c_BEQ, alu(5), alu(4)};
        d_jal = {alu(11), alu(10), c_JAL, alu(8)};

        // Reset with all lanes hitting
        icache_data  = d_alu;
        icache_valid = 4'b1111;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", 32'(fetch_valid), 32'h0);
        chk("reset_taken", 32'(fetch_pred_taken), 32'h0);
        chk("reset_req",   32'(bp_req_valid), 32'h0);
        chk("reset_addr",  icache_addr, 32'h100);
        reset = 1'b0;
        push_exp(4, 32'h100, d_alu, 4'b0000, 32'h0);
        @(negedge clock);
        icache_valid = '0;
        chk("full_next_addr", icache_addr, 32'h110);

        // Partial hit 1011 at 0x200: only the leading two lanes
        redirect(32'h200);
        chk("redirect_addr", icache_addr, 32'h200);
        icache_data  = d_alu;
        icache_valid = 4'b1011;
        push_exp(2, 32'h200, d_alu, 4'b0000, 32'h0);
        @(negedge clock);
        icache_valid = '0;
        chk("partial_next_addr", icache_addr, 32'h208);

        // Insufficient buffer space stalls, then full bundle goes out
        icache_valid = 4'b1111;
        ib_free      = 3'd2;
        @(negedge clock);
        chk("stall_valid", 32'(fetch_valid), 32'h0);
        chk("stall_addr",  icache_addr, 32'h208);
        ib_free = 3'd4;
        push_exp(4, 32'h208, d_alu, 4'b0000, 32'h0);
        @(negedge clock);
        icache_valid = '0;
        chk("unstall_addr", icache_addr, 32'h218);

        // BEQ in lane 2 at 0x300, predicted taken to 0x500 after a delay
        redirect(32'h300);
        icache_data  = d_br;
        icache_valid = 4'b1111;
        @(negedge clock);
        icache_valid = '0;
        chk("br_req_valid", 32'(bp_req_valid), 32'h1);
        chk("br_req_pc",    bp_req_pc, 32'h308);
        chk("br_no_out",    32'(fetch_valid), 32'h0);
        @(negedge clock);
        chk("br_req_drop",  32'(bp_req_valid), 32'h0);
        @(negedge clock);
        bp_resp_valid  = 1'b1;
        bp_resp_taken  = 1'b1;
        bp_resp_target = 32'h500;
        push_exp(3, 32'h300, d_br, 4'b0100, 32'h500);
        @(negedge clock);
        bp_resp_valid = 1'b0;
        chk("taken_addr", icache_addr, 32'h500);

        // Same bundle, predicted not taken
        redirect(32'h300);
        icache_data  = d_br;
        icache_valid = 4'b1111;
        @(negedge clock);
        icache_valid = '0;
        chk("nt_req_pc", bp_req_pc, 32'h308);
        bp_resp_valid  = 1'b1;
        bp_resp_taken  = 1'b0;
        bp_resp_target = 32'h999;
        push_exp(3, 32'h300, d_br, 4'b0000, 32'h0);
        @(negedge clock);
        bp_resp_valid = 1'b0;
        chk("nt_addr", icache_addr, 32'h30C);

        // Mispredict coincident with response while in PREDICT
        redirect(32'h300);
        icache_data  = d_br;
        icache_valid = 4'b1111;
        @(negedge clock);
        icache_valid   = '0;
        mispredict     = 1'b1;
        pc_update_addr = 32'h800;
        bp_resp_valid  = 1'b1;
        bp_resp_taken  = 1'b1;
        bp_resp_target = 32'h500;
        @(negedge clock);
        mispredict = 1'b0;
        chk("mp_addr",  icache_addr, 32'h800);
        chk("mp_valid", 32'(fetch_valid), 32'h0);
        chk("mp_req",   32'(bp_req_valid), 32'h0);
        @(negedge clock);
        bp_resp_valid = 1'b0;
        chk("stray_addr",  icache_addr, 32'h800);
        chk("stray_valid", 32'(fetch_valid), 32'h0);

        // Misaligned redirect, JAL in lane 1, exact-fit buffer, immediate response
        redirect(32'h903);
        chk("align_addr", icache_addr, 32'h900);
        icache_data  = d_jal;
        icache_valid = 4'b0111;
        ib_free      = 3'd2;
        @(negedge clock);
        icache_valid = '0;
        ib_free      = 3'd4;
        chk("jal_req_pc", bp_req_pc, 32'h904);
        bp_resp_valid  = 1'b1;
        bp_resp_taken  = 1'b1;
        bp_resp_target = 32'hA02;
        push_exp(2, 32'h900, d_jal, 4'b0010, 32'hA02);
        @(negedge clock);
        bp_resp_valid = 1'b0;
        chk("jal_addr", icache_addr, 32'hA00);

        repeat (3) @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
